tx_intf_iq_packer: RTL and testbench
====================================

# tx_intf_iq_packer

Upstream producer for the tx_intf AXI-stream master: captures 32-bit I/Q samples, packs two samples per 64-bit word and writes them into the master's FIFO through the DATA_FROM_ACC / ACC_DATA_READY / FULLN_TO_ACC handshake. It raises start_1trans to launch one DMA transfer per capture. It stops after exactly M_AXIS_NUM_DMA_SYMBOL+1 words, which is the count the master sends. FIFO overflow drops whole words, never half-words, and is reported via a sticky flag and a drop counter.

## Interface
- IQ_DATA_WIDTH, 16, width of I and of Q; one sample is 2*IQ_DATA_WIDTH bits
- C_M_AXIS_TDATA_WIDTH, 64, packed word width; must equal 4*IQ_DATA_WIDTH
- MAX_BIT_NUM_DMA_SYMBOL, 14, width of the word-count configuration and status
- DROP_CNT_BITS, 16, width of the drop counter
- M_AXIS_ACLK  in  1  sole clock
- M_AXIS_ARESETN  in  1  asynchronous, active-low reset
- arm  in  1  level; a rising edge arms a capture, low aborts
- trigger  in  1  level; starts a capture while armed
- endless_mode  in  1  1 = ignore the word limit
- M_AXIS_NUM_DMA_SYMBOL  in  MAX_BIT_NUM_DMA_SYMBOL  capture length minus one, in words
- iq_valid  in  1  sample strobe
- iq_data  in  2*IQ_DATA_WIDTH  {Q, I}
- FULLN_TO_ACC  in  1  FIFO not full
- DATA_FROM_ACC  out  C_M_AXIS_TDATA_WIDTH  packed word
- ACC_DATA_READY  out  1  one-cycle FIFO write strobe
- start_1trans  out  1  high while in CAPTURE
- busy  out  1  state != IDLE
- overflow  out  1  sticky word-drop flag, cleared on arm rising edge
- drop_count  out  DROP_CNT_BITS  saturating count of dropped words
- word_count  out  MAX_BIT_NUM_DMA_SYMBOL  words written in the current or last capture

## Operation
- States: IDLE, ARMED, CAPTURE, DONE.
  - IDLE -> ARMED on arm rising edge (edge detected from a registered copy of arm). The same edge clears overflow, drop_count and word_count.
  - ARMED -> CAPTURE on the first cycle with trigger=1. A trigger in the same cycle as the arm edge is not seen; it is sampled from the next cycle.
  - CAPTURE -> DONE when a write brings word_count to M_AXIS_NUM_DMA_SYMBOL+1 and endless_mode=0.
  - DONE -> IDLE after 1 cycle.
  - ARMED or CAPTURE -> IDLE whenever arm=0; abort takes priority over all other transitions.
- Packing happens only in CAPTURE:
  - The first iq_valid fills half-word slot [31:0]; the second fills [63:32] and completes the pair.
  - Samples in other states are ignored. Entering or leaving CAPTURE clears the half-filled slot; a partial pair is discarded, never written.
- On a completed pair:
  - If FULLN_TO_ACC=1 in that cycle: register the word, pulse ACC_DATA_READY next cycle, word_count += 1.
  - Else: discard the word, set overflow, and increment drop_count (saturates at all-ones). word_count is unchanged.
- The word limit counts written words only; dropped words do not count toward termination.
- In endless mode word_count wraps modulo 2^MAX_BIT_NUM_DMA_SYMBOL and the capture ends only on abort.
- Reset clears every register. All outputs reset to 0, and state resets to IDLE.

## Timing
- Pair completes at cycle t -> DATA_FROM_ACC valid and ACC_DATA_READY=1 at t+1 only. DATA_FROM_ACC holds its last value otherwise.
- FULLN_TO_ACC is sampled at t, combinationally.
  - A pair completes at most every 2nd cycle, so the FIFO must reflect a write at t+1 in FULL by t+2.
- start_1trans rises in the first CAPTURE cycle and falls on entry to DONE or IDLE: one rising edge per capture.
- The last word's ACC_DATA_READY coincides with the DONE cycle.
- An abort in the cycle a pair completes still writes that word (decision made at t). No later word is written.

## Structure
- Shared package tx_intf_pkg:
  - state localparams (IDLE=2'b00, ARMED=2'b01, CAPTURE=2'b10, DONE=2'b11);
  - default widths IQ_DATA_WIDTH and MAX_BIT_NUM_DMA_SYMBOL.
- Sub-module iq_pair_packer: half-slot register, pair-complete flag, output word register and write strobe, with a clear input.
- Top level holds the FSM, arm edge detection, counters and status.
- Target size is about 200 lines.

## Test plan
- NUM_DMA_SYMBOL=3, FULLN=1, 8 samples on consecutive cycles (I=n, Q=0x100+n, n=0..7) after trigger:
  - 4 writes, the first being 0x0101_0001_0100_0000;
  - word_count=4, then one DONE cycle, then IDLE;
  - start_1trans high for exactly the CAPTURE cycles.
- Same config, FULLN=0 during the 2nd pair:
  - word 1 dropped, overflow=1, drop_count=1;
  - capture continues until 4 words are written (10 samples total).
- endless_mode=1, NUM=0, 2^14+2 pairs with FULLN=1: word_count wraps to 2; arm=0 -> IDLE and no further writes.
- Arm edge and trigger in the same cycle, trigger then dropped: stays in ARMED; a later trigger pulse starts the capture.
- Abort after 3 samples, then re-arm and capture 2 samples: first written word contains only the 2 new samples, not the leftover 3rd sample.
- Assert M_AXIS_ARESETN low mid-CAPTURE between clock edges: all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/tx_intf_pkg.sv
// Shared constants for the tx_intf I/Q packing path: FSM encoding and default widths.
// No logic; imported by the packer top level.
package tx_intf_pkg;

    localparam int IQ_DATA_WIDTH          = 16;
    localparam int MAX_BIT_NUM_DMA_SYMBOL = 14;

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] ARMED   = 2'b01;
    localparam logic [1:0] CAPTURE = 2'b10;
    localparam logic [1:0] DONE    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = IDLE,
        ST_ARMED   = ARMED,
        ST_CAPTURE = CAPTURE,
        ST_DONE    = DONE
    } state_t;

endpackage

// File: rtl/tx_intf_iq_packer_if.sv
// Sample-in / packed-word-out bundle between the I/Q source, the packer and the master FIFO.
// master = packer side; slave = the side driving samples and FIFO status.
interface tx_intf_iq_packer_if #(
    parameter int IQ_DATA_WIDTH        = tx_intf_pkg::IQ_DATA_WIDTH,
    parameter int C_M_AXIS_TDATA_WIDTH = 4 * tx_intf_pkg::IQ_DATA_WIDTH
);
    logic                            iq_valid;
    logic [2*IQ_DATA_WIDTH-1:0]      iq_data;
    logic                            FULLN_TO_ACC;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] DATA_FROM_ACC;
    logic                            ACC_DATA_READY;

    modport master (
        input  iq_valid, iq_data, FULLN_TO_ACC,
        output DATA_FROM_ACC, ACC_DATA_READY
    );

    modport slave (
        output iq_valid, iq_data, FULLN_TO_ACC,
        input  DATA_FROM_ACC, ACC_DATA_READY
    );
endinterface

// File: rtl/tx_intf_iq_pair_packer.sv
// Packs two samples into one word; latency 1 cycle from completing sample to write strobe.
// Backpressure: a pair completing while fulln=0 is dropped whole and flagged via pair_drop.
module iq_pair_packer #(
    parameter int SAMPLE_W = 32
) (
    input  logic                  M_AXIS_ACLK,
    input  logic                  M_AXIS_ARESETN,
    input  logic                  clr,
    input  logic                  sample_vld,
    input  logic [SAMPLE_W-1:0]   sample_dat,
    input  logic                  fulln,
    output logic                  pair_wr,
    output logic                  pair_drop,
    output logic [2*SAMPLE_W-1:0] word_dat,
    output logic                  word_vld
);
    logic                half_vld_q;
    logic [SAMPLE_W-1:0] half_dat_q;
    logic                pair_done;

    assign pair_done = sample_vld & half_vld_q;
    assign pair_wr   = pair_done & fulln;
    assign pair_drop = pair_done & ~fulln;

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            half_vld_q <= 1'b0;
            half_dat_q <= '0;
            word_dat   <= '0;
            word_vld   <= 1'b0;
        end else begin
            word_vld <= pair_wr;
            if (pair_wr)
                word_dat <= {sample_dat, half_dat_q};
            if (sample_vld && !half_vld_q)
                half_dat_q <= sample_dat;
            // clr wins so a sample arriving as capture ends cannot seed the next pair
            if (clr)
                half_vld_q <= 1'b0;
            else if (sample_vld)
                half_vld_q <= ~half_vld_q;
        end
    end

endmodule

// File: rtl/tx_intf_iq_packer.sv
// Capture FSM feeding the tx_intf master FIFO with packed I/Q words; write strobe 1 cycle after pair.
// Backpressure: FULLN_TO_ACC low at pair completion drops that word, sets overflow, counts it.
module tx_intf_iq_packer #(
    parameter int IQ_DATA_WIDTH          = tx_intf_pkg::IQ_DATA_WIDTH,
    parameter int C_M_AXIS_TDATA_WIDTH   = 4 * tx_intf_pkg::IQ_DATA_WIDTH,
    parameter int MAX_BIT_NUM_DMA_SYMBOL = tx_intf_pkg::MAX_BIT_NUM_DMA_SYMBOL,
    parameter int DROP_CNT_BITS          = 16
) (
    input  logic                              M_AXIS_ACLK,
    input  logic                              M_AXIS_ARESETN,
    input  logic                              arm,
    input  logic                              trigger,
    input  logic                              endless_mode,
    input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] M_AXIS_NUM_DMA_SYMBOL,
    tx_intf_iq_packer_if.master               bus,
    output logic                              start_1trans,
    output logic                              busy,
    output logic                              overflow,
    output logic [DROP_CNT_BITS-1:0]          drop_count,
    output logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] word_count
);
    import tx_intf_pkg::*;

    state_t state_q, state_d;
    logic   arm_q;
    logic   arm_rise;
    logic   in_cap;
    logic   pack_clr;
    logic   pair_wr;
    logic   pair_drop;
    logic   last_word;

    assign arm_rise  = arm & ~arm_q;
    assign in_cap    = (state_q == ST_CAPTURE);
    assign last_word = pair_wr && !endless_mode && (word_count == M_AXIS_NUM_DMA_SYMBOL);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (arm_rise) state_d = ST_ARMED;
            ST_ARMED: begin
                if (!arm)         state_d = ST_IDLE;
                else if (trigger) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (!arm)           state_d = ST_IDLE;
                else if (last_word) state_d = ST_DONE;
            end
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Half slot only survives while capture continues into the next cycle
    assign pack_clr = !(in_cap && (state_d == ST_CAPTURE));

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state_q    <= ST_IDLE;
            arm_q      <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
            word_count <= '0;
        end else begin
            state_q <= state_d;
            arm_q   <= arm;
            if (state_q == ST_IDLE && arm_rise) begin
                overflow   <= 1'b0;
                drop_count <= '0;
                word_count <= '0;
            end else begin
                if (pair_wr)
                    word_count <= word_count + 1'b1;
                if (pair_drop) begin
                    overflow <= 1'b1;
                    if (drop_count != '1)
                        drop_count <= drop_count + 1'b1;
                end
            end
        end
    end

    assign start_1trans = in_cap;
    assign busy         = (state_q != ST_IDLE);

    iq_pair_packer #(
        .SAMPLE_W (2*IQ_DATA_WIDTH)
    ) u_pair (
        .M_AXIS_ACLK    (M_AXIS_ACLK),
        .M_AXIS_ARESETN (M_AXIS_ARESETN),
        .clr            (pack_clr),
        .sample_vld     (bus.iq_valid & in_cap),
        .sample_dat     (bus.iq_data),
        .fulln          (bus.FULLN_TO_ACC),
        .pair_wr        (pair_wr),
        .pair_drop      (pair_drop),
        .word_dat       (bus.DATA_FROM_ACC),
        .word_vld       (bus.ACC_DATA_READY)
    );

endmodule

// File: tb/tb_tx_intf_iq_packer.sv
// Scoreboard bench for tx_intf_iq_packer: stimulus pushes expected words, a negedge monitor pops them.
module tb_tx_intf_iq_packer;
    localparam int IQW = 16;
    localparam int TDW = 64;
    localparam int NB  = 14;
    localparam int DCB = 16;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b1;
    logic          arm     = 1'b0;
    logic          trigger = 1'b0;
    logic          endless = 1'b0;
    logic [NB-1:0] num     = '0;
    logic          start_1trans, busy, overflow;
    logic [DCB-1:0] drop_count;
    logic [NB-1:0]  word_count;

    tx_intf_iq_packer_if #(.IQ_DATA_WIDTH(IQW), .C_M_AXIS_TDATA_WIDTH(TDW)) bus();

    tx_intf_iq_packer #(
        .IQ_DATA_WIDTH(IQW), .C_M_AXIS_TDATA_WIDTH(TDW),
        .MAX_BIT_NUM_DMA_SYMBOL(NB), .DROP_CNT_BITS(DCB)
    ) dut (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n), .arm(arm), .trigger(trigger),
        .endless_mode(endless), .M_AXIS_NUM_DMA_SYMBOL(num), .bus(bus),
        .start_1trans(start_1trans), .busy(busy), .overflow(overflow),
        .drop_count(drop_count), .word_count(word_count)
    );

    always #5 clk = ~clk;

    logic [63:0] exp_q[$];
    logic [31:0] pend[$];
    int n_checks = 0, n_errors = 0;
    int wr_seen = 0, wr_pushed = 0, start_cycles = 0, cap_cycles = 0;
    int m_written = 0, m_dropped = 0;
    bit first_cap = 1'b0;
    logic [63:0] first_word = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (start_1trans === 1'b1) start_cycles++;
        if (bus.ACC_DATA_READY === 1'b1) begin
            wr_seen++;
            if (first_cap) begin
                first_word = bus.DATA_FROM_ACC;
                first_cap  = 1'b0;
            end
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got %0h expected no write", bus.DATA_FROM_ACC);
            end else begin
                check("data", bus.DATA_FROM_ACC, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        pend.delete();
        m_written    = 0;
        m_dropped    = 0;
        cap_cycles   = 0;
        start_cycles = 0;
    endtask

    // One capture cycle: samples queue up and every second one closes a word
    task automatic cap_cycle(input bit vld, input logic [31:0] dat, input bit full_n);
        logic [63:0] w;
        bus.iq_valid     = vld;
        bus.iq_data      = dat;
        bus.FULLN_TO_ACC = full_n;
        if (vld) begin
            pend.push_back(dat);
            if (pend.size() == 2) begin
                w = {pend[1], pend[0]};
                pend.delete();
                if (full_n) begin
                    exp_q.push_back(w);
                    wr_pushed++;
                    m_written++;
                end else if (m_dropped < (1 << DCB) - 1) begin
                    m_dropped++;
                end
            end
        end
        cap_cycles++;
        tick();
        bus.iq_valid = 1'b0;
    endtask

    task automatic start_capture(input int lim, input bit endl);
        num     = NB'(lim);
        endless = endl;
        arm     = 1'b0;
        tick();
        arm = 1'b1;
        tick();
        check("armed_busy", busy, 1);
        check("armed_start", start_1trans, 0);
        check("arm_clears_word_count", word_count, 0);
        check("arm_clears_overflow", overflow, 0);
        check("arm_clears_drop_count", drop_count, 0);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        model_reset();
    endtask

    task automatic end_capture();
        check("done_word_count", word_count, 64'(m_written % (1 << NB)));
        check("done_busy", busy, 1);
        check("done_start_low", start_1trans, 0);
        check("overflow", overflow, (m_dropped > 0) ? 1 : 0);
        check("drop_count", drop_count, 64'(m_dropped));
        tick();
        check("idle_after_done", busy, 0);
        check("start_cycles", 64'(start_cycles), 64'(cap_cycles));
        check("queue_drained", 64'(exp_q.size()), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] i16;
        int n;
        bus.iq_valid     = 1'b0;
        bus.iq_data      = '0;
        bus.FULLN_TO_ACC = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_data", bus.DATA_FROM_ACC, 0);
        check("rst_ready", bus.ACC_DATA_READY, 0);
        check("rst_busy", busy, 0);
        check("rst_start", start_1trans, 0);
        check("rst_word_count", word_count, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Directed: 8 consecutive samples, 4 words
        start_capture(3, 0);
        first_cap = 1'b1;
        for (int k = 0; k < 8; k++) begin
            i16 = 16'(k);
            cap_cycle(1'b1, {16'h0100 + i16, i16}, 1'b1);
        end
        end_capture();
        check("first_word", first_word, 64'h0101_0001_0100_0000);

        // FIFO full during second pair: that word is dropped, capture runs on
        start_capture(3, 0);
        n = 0;
        while (m_written < 4 && n < 40) begin
            i16 = 16'(n);
            cap_cycle(1'b1, {16'h0100 + i16, i16}, n != 3);
            n++;
        end
        end_capture();

        // Arm edge and trigger together: trigger not seen
        num = NB'(1); endless = 1'b0; arm = 1'b0;
        tick();
        arm = 1'b1; trigger = 1'b1;
        tick();
        trigger = 1'b0;
        tick(); tick();
        check("same_cycle_trig_armed", busy, 1);
        check("same_cycle_trig_no_cap", start_1trans, 0);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        model_reset();
        check("later_trig_cap", start_1trans, 1);
        for (int k = 0; k < 4; k++) cap_cycle(1'b1, $urandom, 1'b1);
        end_capture();

        // Abort with a half-filled slot, then re-arm: leftover must not leak
        start_capture(5, 0);
        for (int k = 0; k < 3; k++) cap_cycle(1'b1, $urandom | 32'h1, 1'b1);
        arm = 1'b0;
        cap_cycle(1'b0, '0, 1'b1);
        check("abort_idle", busy, 0);
        start_capture(0, 0);
        for (int k = 0; k < 2; k++) cap_cycle(1'b1, $urandom, 1'b1);
        end_capture();

        // Abort in the cycle a pair completes: that word is still written, none after
        start_capture(5, 0);
        for (int k = 0; k < 3; k++) cap_cycle(1'b1, $urandom, 1'b1);
        arm = 1'b0;
        cap_cycle(1'b1, $urandom, 1'b1);
        for (int k = 0; k < 3; k++) begin
            bus.iq_valid = 1'b1; bus.iq_data = $urandom;
            tick();
        end
        bus.iq_valid = 1'b0;
        check("abort_pair_idle", busy, 0);
        check("abort_pair_drained", 64'(exp_q.size()), 0);

        // Randomized captures
        for (int t = 0; t < 6; t++) begin
            int lim, cyc;
            lim = $urandom_range(0, 5);
            start_capture(lim, 0);
            cyc = 0;
            while (m_written < lim + 1 && cyc < 500) begin
                cap_cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0);
                cyc++;
            end
            if (cyc >= 500) begin
                n_checks++; n_errors++;
                $display("FAIL random_bound: got %0d words expected %0d", m_written, lim + 1);
            end
            end_capture();
        end

        // Endless mode: word_count wraps, abort stops writes
        start_capture(0, 1);
        for (int p = 0; p < (1 << NB) + 2; p++) begin
            cap_cycle(1'b1, $urandom, 1'b1);
            cap_cycle(1'b1, $urandom, 1'b1);
        end
        check("endless_wrap", word_count, 64'(m_written % (1 << NB)));
        check("endless_still_cap", start_1trans, 1);
        arm = 1'b0;
        cap_cycle(1'b0, '0, 1'b1);
        check("endless_abort_idle", busy, 0);
        for (int k = 0; k < 4; k++) begin
            bus.iq_valid = 1'b1; bus.iq_data = $urandom;
            tick();
        end
        bus.iq_valid = 1'b0;
        check("endless_drained", 64'(exp_q.size()), 0);
        check("write_total", 64'(wr_seen), 64'(wr_pushed));

        // Asynchronous reset between edges mid-capture
        start_capture(2, 0);
        for (int k = 0; k < 3; k++) cap_cycle(1'b1, $urandom | 32'h8000_0001, 1'b1);
        #2;
        rst_n = 1'b0; arm = 1'b0;
        #1;
        check("arst_data", bus.DATA_FROM_ACC, 0);
        check("arst_ready", bus.ACC_DATA_READY, 0);
        check("arst_start", start_1trans, 0);
        check("arst_busy", busy, 0);
        check("arst_word_count", word_count, 0);
        check("arst_overflow", overflow, 0);
        check("arst_drop_count", drop_count, 0);
        #2 rst_n = 1'b1;
        tick();
        start_capture(1, 0);
        for (int k = 0; k < 4; k++) cap_cycle(1'b1, $urandom, 1'b1);
        end_capture();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
